// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: receive-side checker for a VGA timing stream.
// Samples active-low hsync/vsync and blank_n, measures line and frame geometry,
// recovers pixel coordinates, declares lock after clean frames and flags timing errors.
// Ports:
//   VGA_clk     pixel clock, all logic on posedge
//   rst         synchronous active-high reset
//   VGA_Hsync   hsync (active low)       VGA_Vsync  vsync (active low)
//   blank_n     1 = active video         clr_err    pulse, clears err_flags
//   xPixel/yPixel  recovered column/row, valid when pix_valid
//   pix_valid   registered copy of sampled blank_n
//   h_total/hsync_w  last line period / hsync width (clocks)
//   v_total/vsync_w  last frame height / vsync width (lines)
//   locked      1 in LOCKED state
//   err_pulse   1-cycle pulse on any mismatch
//   err_flags   sticky [0]h_total [1]hsync_w [2]v_total [3]vsync_w [4]active
module vga_sync_monitor #(
   parameter int unsigned EXP_H_TOTAL = 794,
   parameter int unsigned EXP_HSYNC_W = 92,
   parameter int unsigned EXP_V_TOTAL = 526,
   parameter int unsigned EXP_VSYNC_W = 2,
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic        VGA_clk,
   input  logic        rst,
   input  logic        VGA_Hsync,
   input  logic        VGA_Vsync,
   input  logic        blank_n,
   input  logic        clr_err,
   output logic [9:0]  xPixel,
   output logic [9:0]  yPixel,
   output logic        pix_valid,
   output logic [10:0] h_total,
   output logic [10:0] hsync_w,
   output logic [9:0]  v_total,
   output logic [9:0]  vsync_w,
   output logic        locked,
   output logic        err_pulse,
   output logic [4:0]  err_flags
);

   localparam int unsigned GoodW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

   localparam logic [10:0]      Max11     = 11'h7ff;
   localparam logic [9:0]       Max10     = 10'h3ff;
   localparam logic [10:0]      ExpHTotal = 11'(EXP_H_TOTAL);
   localparam logic [10:0]      ExpHsyncW = 11'(EXP_HSYNC_W);
   localparam logic [10:0]      ExpVTotal = 11'(EXP_V_TOTAL);
   localparam logic [9:0]       ExpVsyncW = 10'(EXP_VSYNC_W);
   localparam logic [10:0]      HActive   = 11'(H_ACTIVE);
   localparam logic [9:0]       VActive   = 10'(V_ACTIVE);
   localparam logic [10:0]      VLostLim  = 11'(2 * EXP_V_TOTAL);
   localparam logic [GoodW-1:0] LockFrms  = GoodW'(LOCK_FRAMES);

   typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

   state_e           state_q, state_d;
   logic [GoodW-1:0] good_q, good_d;
   logic             bad_q, bad_d;
   logic             h_seen_q, h_seen_d;
   logic             s_hs_q, s_vs_q, s_bl_q, d_hs_q, d_vs_q, d_bl_q;
   // v_cnt is one bit wider than v_total so the vsync-lost limit (2x frame) is reachable.
   logic [10:0]      h_cnt_q, h_cnt_d, hw_cnt_q, hw_cnt_d, v_cnt_q, v_cnt_d, a_cnt_q, a_cnt_d;
   logic [9:0]       vw_cnt_q, vw_cnt_d, al_cnt_q, al_cnt_d;
   logic [9:0]       x_q, x_d, y_q, y_d;
   logic             y_first_q, y_first_d;
   logic             pix_valid_q, pix_valid_d;
   logic [10:0]      h_total_q, h_total_d, hsync_w_q, hsync_w_d;
   logic [9:0]       v_total_q, v_total_d, vsync_w_q, vsync_w_d;
   logic             err_pulse_q, err_pulse_d;
   logic [4:0]       err_flags_q, err_flags_d;

   logic             hs_fall, hs_rise, vs_fall, vs_rise, bl_rise, bl_fall;
   logic [10:0]      h_inc;
   logic [4:0]       err_now;
   logic             lost;
   logic [GoodW-1:0] good_inc;

   assign hs_fall  = d_hs_q & ~s_hs_q;
   assign hs_rise  = ~d_hs_q & s_hs_q;
   assign vs_fall  = d_vs_q & ~s_vs_q;
   assign vs_rise  = ~d_vs_q & s_vs_q;
   assign bl_rise  = ~d_bl_q & s_bl_q;
   assign bl_fall  = d_bl_q & ~s_bl_q;
   assign h_inc    = (h_cnt_q == Max11) ? Max11 : h_cnt_q + 11'd1;
   assign lost     = (v_cnt_q > VLostLim) | (h_cnt_q == Max11);
   assign good_inc = good_q + GoodW'(1);

   // Mismatch detection, only meaningful once the stream has been acquired.
   always_comb begin
      err_now = '0;
      if (state_q != StSearch) begin
         err_now[0] = hs_fall & h_seen_q & (h_inc != ExpHTotal);
         err_now[1] = hs_rise & (hw_cnt_q != ExpHsyncW);
         err_now[2] = vs_fall & (v_cnt_q != ExpVTotal);
         err_now[3] = vs_rise & (vw_cnt_q != ExpVsyncW);
         err_now[4] = (bl_fall & (a_cnt_q != HActive)) | (vs_fall & (al_cnt_q != VActive));
      end
   end

   // Geometry counters and coordinate recovery.
   always_comb begin
      h_cnt_d     = hs_fall ? 11'd0 : h_inc;
      h_total_d   = (hs_fall && h_seen_q) ? h_inc : h_total_q;
      hw_cnt_d    = s_hs_q ? 11'd0 : ((hw_cnt_q == Max11) ? Max11 : hw_cnt_q + 11'd1);
      hsync_w_d   = hs_rise ? hw_cnt_q : hsync_w_q;
      v_cnt_d     = v_cnt_q;
      if (vs_fall) v_cnt_d = 11'd0;
      else if (hs_fall && v_cnt_q != Max11) v_cnt_d = v_cnt_q + 11'd1;
      v_total_d   = v_total_q;
      if (vs_fall) v_total_d = (v_cnt_q > {1'b0, Max10}) ? Max10 : v_cnt_q[9:0];
      vw_cnt_d    = vw_cnt_q;
      if (s_vs_q) vw_cnt_d = 10'd0;
      else if (hs_fall && vw_cnt_q != Max10) vw_cnt_d = vw_cnt_q + 10'd1;
      vsync_w_d   = vs_rise ? vw_cnt_q : vsync_w_q;
      a_cnt_d     = s_bl_q ? ((a_cnt_q == Max11) ? Max11 : a_cnt_q + 11'd1) : 11'd0;
      al_cnt_d    = al_cnt_q;
      if (vs_fall) al_cnt_d = 10'd0;
      else if (bl_rise && al_cnt_q != Max10) al_cnt_d = al_cnt_q + 10'd1;
      pix_valid_d = s_bl_q;
      x_d         = x_q;
      if (bl_rise) x_d = 10'd0;
      else if (s_bl_q) x_d = x_q + 10'd1;
      y_d         = y_q;
      y_first_d   = y_first_q;
      if (bl_rise) begin
         y_d       = y_first_q ? 10'd0 : y_q + 10'd1;
         y_first_d = 1'b0;
      end
      if (vs_fall) y_first_d = 1'b1;
      err_pulse_d = |err_now;
      // A new error beats a simultaneous clear.
      err_flags_d = (clr_err ? 5'd0 : err_flags_q) | err_now;
   end

   // Lock state machine.
   always_comb begin
      state_d  = state_q;
      good_d   = good_q;
      bad_d    = bad_q | (|err_now);
      h_seen_d = h_seen_q | hs_fall;
      unique case (state_q)
         StSearch: begin
            if (vs_fall) begin
               state_d = StTrack;
               good_d  = '0;
               bad_d   = 1'b0;
            end
         end
         StTrack: begin
            if (lost) begin
               state_d  = StSearch;
               h_seen_d = 1'b0;
            end else if (vs_fall) begin
               bad_d = 1'b0;
               if (bad_q || (|err_now)) begin
                  good_d = '0;
               end else begin
                  good_d = good_inc;
                  if (good_inc == LockFrms) state_d = StLocked;
               end
            end
         end
         StLocked: begin
            if (lost) begin
               state_d  = StSearch;
               h_seen_d = 1'b0;
            end else begin
               if (|err_now) begin
                  state_d = StTrack;
                  good_d  = '0;
               end
               if (vs_fall) bad_d = 1'b0;
            end
         end
         default: state_d = StSearch;
      endcase
   end

   always_ff @(posedge VGA_clk) begin
      if (rst) begin
         s_hs_q      <= 1'b1;
         s_vs_q      <= 1'b1;
         s_bl_q      <= 1'b0;
         d_hs_q      <= 1'b1;
         d_vs_q      <= 1'b1;
         d_bl_q      <= 1'b0;
         state_q     <= StSearch;
         good_q      <= '0;
         bad_q       <= 1'b0;
         h_seen_q    <= 1'b0;
         h_cnt_q     <= '0;
         hw_cnt_q    <= '0;
         v_cnt_q     <= '0;
         vw_cnt_q    <= '0;
         a_cnt_q     <= '0;
         al_cnt_q    <= '0;
         x_q         <= '0;
         y_q         <= '0;
         // Rows before the first vsync still number from zero.
         y_first_q   <= 1'b1;
         pix_valid_q <= 1'b0;
         h_total_q   <= '0;
         hsync_w_q   <= '0;
         v_total_q   <= '0;
         vsync_w_q   <= '0;
         err_pulse_q <= 1'b0;
         err_flags_q <= '0;
      end else begin
         s_hs_q      <= VGA_Hsync;
         s_vs_q      <= VGA_Vsync;
         s_bl_q      <= blank_n;
         d_hs_q      <= s_hs_q;
         d_vs_q      <= s_vs_q;
         d_bl_q      <= s_bl_q;
         state_q     <= state_d;
         good_q      <= good_d;
         bad_q       <= bad_d;
         h_seen_q    <= h_seen_d;
         h_cnt_q     <= h_cnt_d;
         hw_cnt_q    <= hw_cnt_d;
         v_cnt_q     <= v_cnt_d;
         vw_cnt_q    <= vw_cnt_d;
         a_cnt_q     <= a_cnt_d;
         al_cnt_q    <= al_cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         y_first_q   <= y_first_d;
         pix_valid_q <= pix_valid_d;
         h_total_q   <= h_total_d;
         hsync_w_q   <= hsync_w_d;
         v_total_q   <= v_total_d;
         vsync_w_q   <= vsync_w_d;
         err_pulse_q <= err_pulse_d;
         err_flags_q <= err_flags_d;
      end
   end

   assign xPixel    = x_q;
   assign yPixel    = y_q;
   assign pix_valid = pix_valid_q;
   assign h_total   = h_total_q;
   assign hsync_w   = hsync_w_q;
   assign v_total   = v_total_q;
   assign vsync_w   = vsync_w_q;
   assign locked    = (state_q == StLocked);
   assign err_pulse = err_pulse_q;
   assign err_flags = err_flags_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a scaled-down timing geometry
// (40-clock lines, 6-clock hsync, 24 active pixels, 12-line frames, 8 active lines).
module tb_vga_sync_monitor;

   localparam int HT  = 40;
   localparam int HSW = 6;
   localparam int HB  = 10;   // first active column
   localparam int HA  = 24;
   localparam int VT  = 12;
   localparam int VSW = 2;
   localparam int VA  = 8;
   localparam int VFL = 9;    // line where vsync falls (column 20)

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hs = 1'b1, vs = 1'b1, bl = 1'b0, clr = 1'b0;
   logic [9:0]  xPixel, yPixel, v_total, vsync_w;
   logic [10:0] h_total, hsync_w;
   logic        pix_valid, locked, err_pulse;
   logic [4:0]  err_flags;

   int n_cmp = 0;
   int n_bad = 0;
   int n_pulse = 0;
   int pv_cnt = 0;
   int p0;
   logic       pulse_locked = 1'b1;
   logic       pv_prev = 1'b0;
   logic [9:0] last_x = '0, last_y = '0, first_x = 10'h3ff;

   always #5 clk = ~clk;

   vga_sync_monitor #(
      .EXP_H_TOTAL(HT), .EXP_HSYNC_W(HSW), .EXP_V_TOTAL(VT), .EXP_VSYNC_W(VSW),
      .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2)
   ) dut (
      .VGA_clk(clk), .rst(rst), .VGA_Hsync(hs), .VGA_Vsync(vs), .blank_n(bl),
      .clr_err(clr), .xPixel(xPixel), .yPixel(yPixel), .pix_valid(pix_valid),
      .h_total(h_total), .hsync_w(hsync_w), .v_total(v_total), .vsync_w(vsync_w),
      .locked(locked), .err_pulse(err_pulse), .err_flags(err_flags)
   );

   // Output monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (err_pulse === 1'b1) begin
         n_pulse++;
         pulse_locked = locked;
      end
      if (pix_valid === 1'b1) begin
         pv_cnt++;
         last_x = xPixel;
         last_y = yPixel;
         if (!pv_prev) first_x = xPixel;
      end
      pv_prev = pix_valid;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   task automatic drive(input int l, input int c, input int hsw, input bit vs_en);
      hs = (c >= hsw);
      bl = (l < VA) && (c >= HB) && (c < HB + HA);
      if (vs_en && l == VFL && c == 20) vs = 1'b0;
      if (vs_en && l == VFL + VSW && c == 20) vs = 1'b1;
   endtask

   task automatic gen_line(input int l, input int htot, input int hsw, input bit vs_en);
      for (int c = 0; c < htot; c++) begin
         @(negedge clk);
         drive(l, c, hsw, vs_en);
      end
   endtask

   task automatic gen_frame();
      for (int l = 0; l < VT; l++) gen_line(l, HT, HSW, 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({xPixel, yPixel, pix_valid, h_total, hsync_w, v_total, vsync_w, locked, err_pulse,
           err_flags} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got x=%0d y=%0d ht=%0d hw=%0d vt=%0d vw=%0d lk=%0b ef=%b want all 0",
                  xPixel, yPixel, h_total, hsync_w, v_total, vsync_w, locked, err_flags);
      end
      rst = 1'b0;
   endtask

   task automatic test_nominal();
      gen_frame();
      n_cmp++;
      if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_f1: got %b want 0", locked); end
      gen_frame();
      n_cmp++;
      if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_f2: got %b want 0", locked); end
      gen_frame();
      n_cmp++;
      if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_f3: got %b want 1", locked); end
      n_cmp++;
      if (h_total !== 11'd40) begin n_bad++; $display("FAIL h_total: got %0d want 40", h_total); end
      n_cmp++;
      if (hsync_w !== 11'd6) begin n_bad++; $display("FAIL hsync_w: got %0d want 6", hsync_w); end
      n_cmp++;
      if (v_total !== 10'd12) begin n_bad++; $display("FAIL v_total: got %0d want 12", v_total); end
      n_cmp++;
      if (vsync_w !== 10'd2) begin n_bad++; $display("FAIL vsync_w: got %0d want 2", vsync_w); end
      n_cmp++;
      if (err_flags !== 5'd0 || n_pulse != 0) begin
         n_bad++;
         $display("FAIL nominal_err: got flags=%b pulses=%0d want 0/0", err_flags, n_pulse);
      end
      pv_cnt = 0;
      gen_frame();
      n_cmp++;
      if (pv_cnt != VA * HA) begin n_bad++; $display("FAIL pix_count: got %0d want %0d", pv_cnt, VA * HA); end
      n_cmp++;
      if (last_x !== 10'd23 || first_x !== 10'd0) begin
         n_bad++;
         $display("FAIL x_range: got first=%0d last=%0d want 0/23", first_x, last_x);
      end
      n_cmp++;
      if (last_y !== 10'd7) begin n_bad++; $display("FAIL y_last: got %0d want 7", last_y); end
   endtask

   task automatic test_long_line();
      p0 = n_pulse;
      for (int l = 0; l < VT; l++) gen_line(l, (l == 3) ? HT + 6 : HT, HSW, 1'b1);
      n_cmp++;
      if (n_pulse - p0 != 1 || pulse_locked !== 1'b0) begin
         n_bad++;
         $display("FAIL long_pulse: got pulses=%0d lk_at_pulse=%b want 1/0", n_pulse - p0, pulse_locked);
      end
      n_cmp++;
      if (err_flags !== 5'b00001) begin n_bad++; $display("FAIL long_flags: got %b want 00001", err_flags); end
      n_cmp++;
      if (locked !== 1'b0) begin n_bad++; $display("FAIL long_unlock: got %b want 0", locked); end
      gen_frame();
      n_cmp++;
      if (locked !== 1'b0) begin n_bad++; $display("FAIL relock_early: got %b want 0", locked); end
      gen_frame();
      n_cmp++;
      if (locked !== 1'b1) begin n_bad++; $display("FAIL relock: got %b want 1", locked); end
      fork
         gen_line(0, HT, HSW, 1'b1);
         begin
            repeat (3) @(negedge clk);
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
            repeat (2) @(negedge clk);
            n_cmp++;
            if (err_flags !== 5'd0) begin n_bad++; $display("FAIL clr_err: got %b want 0", err_flags); end
         end
      join
      for (int l = 1; l < VT; l++) gen_line(l, HT, HSW, 1'b1);
   endtask

   task automatic test_short_hsync();
      p0 = n_pulse;
      for (int l = 0; l < 4; l++) gen_line(l, HT, (l == 3) ? HSW - 2 : HSW, 1'b1);
      n_cmp++;
      if (hsync_w !== 11'd4) begin n_bad++; $display("FAIL short_hsw: got %0d want 4", hsync_w); end
      n_cmp++;
      if (err_flags !== 5'b00010) begin n_bad++; $display("FAIL short_flags: got %b want 00010", err_flags); end
      n_cmp++;
      if (locked !== 1'b0 || n_pulse - p0 != 1 || pulse_locked !== 1'b0) begin
         n_bad++;
         $display("FAIL short_unlock: got lk=%b pulses=%0d want 0/1", locked, n_pulse - p0);
      end
      for (int l = 4; l < VT; l++) gen_line(l, HT, HSW, 1'b1);
      gen_frame();
      gen_frame();
      n_cmp++;
      if (locked !== 1'b1 || hsync_w !== 11'd6) begin
         n_bad++;
         $display("FAIL short_relock: got lk=%b hw=%0d want 1/6", locked, hsync_w);
      end
   endtask

   task automatic test_vsync_loss();
      p0 = n_pulse;
      // Two hsync falls already counted since the last vsync fall; 22 more reach the limit.
      for (int i = 0; i < 22; i++) gen_line(i % VT, HT, HSW, 1'b0);
      n_cmp++;
      if (locked !== 1'b1) begin n_bad++; $display("FAIL vloss_early: got %b want 1", locked); end
      gen_line(22 % VT, HT, HSW, 1'b0);
      n_cmp++;
      if (locked !== 1'b0 || n_pulse != p0) begin
         n_bad++;
         $display("FAIL vloss: got lk=%b pulses=%0d want 0/0", locked, n_pulse - p0);
      end
      gen_line(23 % VT, HT, HSW, 1'b0);
      gen_frame();
      gen_frame();
      n_cmp++;
      if (locked !== 1'b0) begin n_bad++; $display("FAIL vloss_relock_early: got %b want 0", locked); end
      gen_frame();
      n_cmp++;
      if (locked !== 1'b1) begin n_bad++; $display("FAIL vloss_relock: got %b want 1", locked); end
   endtask

   task automatic test_hsync_hold();
      p0 = n_pulse;
      repeat (1900) @(negedge clk);
      n_cmp++;
      if (locked !== 1'b1) begin n_bad++; $display("FAIL hold_early: got %b want 1", locked); end
      repeat (1100) @(negedge clk);
      n_cmp++;
      if (dut.h_cnt_q !== 11'd2047) begin n_bad++; $display("FAIL h_cnt_sat: got %0d want 2047", dut.h_cnt_q); end
      n_cmp++;
      if (locked !== 1'b0 || n_pulse != p0 || h_total !== 11'd40) begin
         n_bad++;
         $display("FAIL hold_search: got lk=%b pulses=%0d ht=%0d want 0/0/40", locked, n_pulse - p0, h_total);
      end
      gen_frame();
      gen_frame();
      gen_frame();
      n_cmp++;
      if (locked !== 1'b1) begin n_bad++; $display("FAIL hold_relock: got %b want 1", locked); end
   endtask

   task automatic test_reset_midline();
      for (int l = 0; l < 4; l++) gen_line(l, HT, HSW, 1'b1);
      for (int c = 0; c < HT; c++) begin
         @(negedge clk);
         drive(4, c, HSW, 1'b1);
         if (c == 15) rst = 1'b1;
         if (c == 16) begin
            rst = 1'b0;
            n_cmp++;
            if ({xPixel, yPixel, pix_valid, h_total, hsync_w, v_total, vsync_w, locked, err_pulse,
                 err_flags} !== '0) begin
               n_bad++;
               $display("FAIL midline_reset: got x=%0d y=%0d pv=%b ht=%0d hw=%0d vt=%0d vw=%0d lk=%b ef=%b want all 0",
                        xPixel, yPixel, pix_valid, h_total, hsync_w, v_total, vsync_w, locked, err_flags);
            end
         end
      end
      for (int l = 5; l < VT; l++) gen_line(l, HT, HSW, 1'b1);
      n_cmp++;
      if (locked !== 1'b0) begin n_bad++; $display("FAIL rst_relock_1: got %b want 0", locked); end
      gen_frame();
      n_cmp++;
      if (locked !== 1'b0) begin n_bad++; $display("FAIL rst_relock_2: got %b want 0", locked); end
      gen_frame();
      n_cmp++;
      if (locked !== 1'b1) begin n_bad++; $display("FAIL rst_relock_3: got %b want 1", locked); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_long_line();
      test_short_hsync();
      test_vsync_loss();
      test_hsync_hold();
      test_reset_midline();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
